// File: rtl/int_float_conv_pipe.sv
// Pipelined int<->IEEE-754 converter; INT_FLOAT_CONV_RNE_EN selects round-to-nearest-even for int->float (else truncate).
// Latency 3 cycles, throughput 1/cycle; global stall, in_ready = ~s3 valid | out_ready.
// Backpressure: all stages hold while a result waits on out_ready; reset discards everything in flight.
module int_float_conv_pipe #(
  parameter int INT_W = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [INT_W-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inexact,
  output logic             out_invalid
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int POS_W = $clog2(INT_W);
  localparam int EXT_W = INT_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] EXP_OVF  = EXP_W'(BIAS + INT_W - 1);
  localparam logic [INT_W-1:0] INT_MAX  = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN  = {1'b1, {(INT_W-1){1'b0}}};

  logic advance;
  logic s3_vld;

  assign advance   = ~s3_vld | out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_vld;

  // ---------------- S1: sign/magnitude, unpack, classify ----------------
  logic             s1_vld, s1_mode, s1_sign, s1_zero, s1_nan;
  logic [TAG_W-1:0] s1_tag;
  logic [INT_W-1:0] s1_mag;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man;

  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;

  assign in_sign = in_data[INT_W-1];
  assign in_exp  = in_data[INT_W-2 -: EXP_W];
  assign in_man  = in_data[MAN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_mode <= 1'b0;
      s1_tag  <= '0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_exp  <= '0;
      s1_man  <= '0;
      s1_zero <= 1'b0;
      s1_nan  <= 1'b0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_mode <= in_mode;
      s1_tag  <= in_tag;
      s1_sign <= in_sign;
      // INT_MIN negates to itself, which reads as the unsigned 2^(INT_W-1)
      s1_mag  <= in_sign ? -in_data : in_data;
      s1_exp  <= in_exp;
      s1_man  <= in_man;
      s1_zero <= ~|in_exp & ~|in_man;
      s1_nan  <= (&in_exp) & (|in_man);
    end
  end

  // ---------------- S2: leading one / exponent decode ----------------
  function automatic logic [POS_W-1:0] msb_pos(input logic [INT_W-1:0] v);
    msb_pos = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (v[i]) msb_pos = POS_W'(i);
    end
  endfunction

  logic             f_small, f_ovf, f_min, f_sat;
  logic [POS_W-1:0] f_sh, i_lead;

  // Exact -2^(INT_W-1) is the only in-range value at the overflow exponent
  assign f_small = s1_exp < EXP_BIAS;
  assign f_ovf   = s1_exp >= EXP_OVF;
  assign f_min   = s1_sign & (s1_exp == EXP_OVF) & ~|s1_man;
  assign f_sat   = s1_nan | (f_ovf & ~f_min);
  assign f_sh    = s1_exp[POS_W-1:0] - EXP_BIAS[POS_W-1:0];
  assign i_lead  = msb_pos(s1_mag);

  logic             s2_vld, s2_mode, s2_sign, s2_zero, s2_inx0, s2_sat;
  logic [TAG_W-1:0] s2_tag;
  logic [INT_W-1:0] s2_mag;
  logic [MAN_W-1:0] s2_man;
  logic [POS_W-1:0] s2_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_mode <= 1'b0;
      s2_tag  <= '0;
      s2_sign <= 1'b0;
      s2_mag  <= '0;
      s2_man  <= '0;
      s2_sh   <= '0;
      s2_zero <= 1'b0;
      s2_inx0 <= 1'b0;
      s2_sat  <= 1'b0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_mode <= s1_mode;
      s2_tag  <= s1_tag;
      // On saturation the sign selects the limit; NaN always goes to INT_MAX
      s2_sign <= (s1_mode & f_sat) ? (s1_sign & ~s1_nan) : s1_sign;
      s2_mag  <= s1_mag;
      s2_man  <= s1_man;
      s2_sh   <= s1_mode ? f_sh : i_lead;
      s2_zero <= s1_mode & f_small;
      s2_inx0 <= ~s1_zero;
      s2_sat  <= s1_mode & f_sat;
    end
  end

  // ---------------- S3: shift, round, pack, flags ----------------
  logic [POS_W-1:0] i_lsh;
  logic [INT_W-1:0] i_norm;
  logic [MAN_W-1:0] i_mant, i_mant_r;
  logic [EXP_W-1:0] i_exp, i_exp_r;
  logic             i_guard, i_sticky;
  logic [INT_W-1:0] i2f_data;

  assign i_lsh    = POS_W'(INT_W - 1) - s2_sh;
  assign i_norm   = s2_mag << i_lsh;
  assign i_mant   = i_norm[INT_W-2 -: MAN_W];
  assign i_guard  = i_norm[INT_W-2-MAN_W];
  assign i_sticky = |i_norm[INT_W-3-MAN_W:0];
  assign i_exp    = EXP_W'(s2_sh) + EXP_BIAS;

`ifdef INT_FLOAT_CONV_RNE_EN
  logic i_up, i_carry;
  assign i_up = i_guard & (i_sticky | i_mant[0]);
  // Mantissa carry-out wraps the mantissa to zero and bumps the exponent
  assign {i_carry, i_mant_r} = {1'b0, i_mant} + {{MAN_W{1'b0}}, i_up};
  assign i_exp_r = i_exp + {{(EXP_W-1){1'b0}}, i_carry};
`else
  assign i_mant_r = i_mant;
  assign i_exp_r  = i_exp;
`endif

  // Normalised msb clear means the integer was zero
  assign i2f_data = i_norm[INT_W-1] ? {s2_sign, i_exp_r, i_mant_r} : '0;

  logic [EXT_W-1:0] f_ext;
  logic [INT_W-1:0] f_imag, f2i_data;
  logic             f_frac, f2i_inexact;

  assign f_ext  = EXT_W'({1'b1, s2_man}) << s2_sh;
  assign f_imag = f_ext[MAN_W +: INT_W];
  assign f_frac = |f_ext[MAN_W-1:0];

  always_comb begin
    f2i_data    = s2_sign ? -f_imag : f_imag;
    f2i_inexact = f_frac;
    if (s2_sat) begin
      f2i_data    = s2_sign ? INT_MIN : INT_MAX;
      f2i_inexact = 1'b0;
    end else if (s2_zero) begin
      f2i_data    = '0;
      f2i_inexact = s2_inx0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_vld      <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_inexact <= 1'b0;
      out_invalid <= 1'b0;
    end else if (advance) begin
      s3_vld      <= s2_vld;
      out_tag     <= s2_tag;
      out_data    <= s2_mode ? f2i_data : i2f_data;
      out_inexact <= s2_mode ? f2i_inexact : (i_guard | i_sticky);
      out_invalid <= s2_mode & s2_sat;
    end
  end

endmodule

// File: tb/tb_int_float_conv_pipe.sv
// Directed scoreboard bench for int_float_conv_pipe: 32-bit and 64-bit instances.
module tb_int_float_conv_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_in_valid = 0, a_in_ready, a_in_mode = 0, a_out_valid, a_out_ready = 1;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [3:0]  a_in_tag = 0, a_out_tag;
  logic        a_out_inexact, a_out_invalid;

  logic        b_in_valid = 0, b_in_ready, b_in_mode = 0, b_out_valid, b_out_ready = 1;
  logic [63:0] b_in_data = 0, b_out_data;
  logic [3:0]  b_in_tag = 0, b_out_tag;
  logic        b_out_inexact, b_out_invalid;

  int_float_conv_pipe dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_inexact(a_out_inexact), .out_invalid(a_out_invalid)
  );

  int_float_conv_pipe #(.INT_W(64), .EXP_W(11), .MAN_W(52), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_inexact(b_out_inexact), .out_invalid(b_out_invalid)
  );

  typedef struct {
    logic [63:0] dat;
    logic [3:0]  tag;
    logic        inx;
    logic        inv;
    int          in_cyc;
    logic        lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  task automatic cmp_out(input string who, input exp_t e, input logic [63:0] d,
                         input logic [3:0] t, input logic inx, input logic inv);
    chk({who, " data"}, d, e.dat);
    chk({who, " tag"}, {60'd0, t}, {60'd0, e.tag});
    chk({who, " inexact"}, {63'd0, inx}, {63'd0, e.inx});
    chk({who, " invalid"}, {63'd0, inv}, {63'd0, e.inv});
    if (e.lat) chk({who, " latency"}, 64'(cyc), 64'(e.in_cyc + 3));
  endtask

  // Output monitors: sample at negedge, a handshake happens on the next posedge
  logic        a_hold = 0, saw_stall = 0;
  logic [31:0] a_hold_dat;
  logic [3:0]  a_hold_tag;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_hold = 0;
      end else begin
        if (a_hold && a_out_valid) begin
          chk("A held data", {32'd0, a_out_data}, {32'd0, a_hold_dat});
          chk("A held tag", {60'd0, a_out_tag}, {60'd0, a_hold_tag});
        end
        if (a_out_valid && !a_out_ready) begin
          chk("A in_ready under stall", {63'd0, a_in_ready}, 64'd0);
          saw_stall = 1;
        end
        a_hold     = a_out_valid && !a_out_ready;
        a_hold_dat = a_out_data;
        a_hold_tag = a_out_tag;
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) chk("A spurious out_valid", {63'd0, a_out_valid}, 64'd0);
          else begin
            e = qa.pop_front();
            cmp_out("A", e, {32'd0, a_out_data}, a_out_tag, a_out_inexact, a_out_invalid);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("B spurious out_valid", {63'd0, b_out_valid}, 64'd0);
        else begin
          e = qb.pop_front();
          cmp_out("B", e, b_out_data, b_out_tag, b_out_inexact, b_out_invalid);
        end
      end
    end
  end

  // Holds out_ready low for 4 cycles once the first result shows up
  logic stall_arm = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_arm && a_out_valid) begin
        stall_arm   = 0;
        a_out_ready = 0;
        repeat (4) @(posedge clk);
        #1 a_out_ready = 1;
      end
    end
  end

  task automatic send(input bit sel, input bit m, input logic [63:0] d, input logic [3:0] t,
                      input logic [63:0] ed, input bit einx, input bit einv, input bit lat);
    exp_t e;
    int   k = 0;
    bit   r = 0;
    if (!sel) begin
      a_in_valid = 1; a_in_mode = m; a_in_data = d[31:0]; a_in_tag = t;
    end else begin
      b_in_valid = 1; b_in_mode = m; b_in_data = d; b_in_tag = t;
    end
    while (!r && k < 100) begin
      @(negedge clk);
      r = sel ? b_in_ready : a_in_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!r) chk("input handshake timeout", {63'd0, r}, 64'd1);
    else begin
      e = '{ed, t, einx, einv, cyc - 1, lat};
      if (!sel) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  task automatic idle();
    a_in_valid = 0;
    b_in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("scoreboard drained", 64'(qa.size() + qb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

`ifdef INT_FLOAT_CONV_RNE_EN
  localparam logic [63:0] E_01000003 = 64'h4B800002;
  localparam logic [63:0] E_7FFFFFFF = 64'h4F000000;
`else
  localparam logic [63:0] E_01000003 = 64'h4B800001;
  localparam logic [63:0] E_7FFFFFFF = 64'h4EFFFFFF;
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("reset out_data", {32'd0, a_out_data}, 64'd0);
    chk("reset out_tag", {60'd0, a_out_tag}, 64'd0);
    chk("reset flags", {62'd0, a_out_inexact, a_out_invalid}, 64'd0);
    rst = 0;
    #1 chk("in_ready after reset", {63'd0, a_in_ready}, 64'd1);

    // Mixed-mode back-to-back stream, no stalls, latency checked
    send(0, 0, 64'h00000001, 4'd0,  64'h3F800000, 0, 0, 1);
    send(0, 0, 64'hFFFFFFFF, 4'd1,  64'hBF800000, 0, 0, 1);
    send(0, 0, 64'h00000000, 4'd2,  64'h00000000, 0, 0, 1);
    send(0, 0, 64'h80000000, 4'd3,  64'hCF000000, 0, 0, 1);
    send(0, 0, 64'h01000003, 4'd4,  E_01000003,   1, 0, 1);
    send(0, 1, 64'h40490FDB, 4'd5,  64'h00000003, 1, 0, 1);
    send(0, 0, 64'h00FFFFFF, 4'd6,  64'h4B7FFFFF, 0, 0, 1);
    send(0, 1, 64'hC0200000, 4'd7,  64'hFFFFFFFE, 1, 0, 1);
    send(0, 1, 64'hCF000000, 4'd8,  64'h80000000, 0, 0, 1);
    send(0, 1, 64'h4F000000, 4'd9,  64'h7FFFFFFF, 0, 1, 1);
    send(0, 1, 64'h7FC00000, 4'd10, 64'h7FFFFFFF, 0, 1, 1);
    send(0, 1, 64'h00000001, 4'd11, 64'h00000000, 1, 0, 1);
    send(0, 0, 64'h7FFFFFFF, 4'd12, E_7FFFFFFF,   1, 0, 1);
    send(0, 1, 64'hFF800000, 4'd13, 64'h80000000, 0, 1, 1);
    send(0, 1, 64'hCF000001, 4'd14, 64'h80000000, 0, 1, 1);
    send(0, 1, 64'h4EFFFFFF, 4'd15, 64'h7FFFFF80, 0, 0, 1);
    send(0, 1, 64'h3F800000, 4'd0,  64'h00000001, 0, 0, 1);
    send(0, 1, 64'hBF000000, 4'd1,  64'h00000000, 1, 0, 1);
    send(0, 1, 64'h80000000, 4'd2,  64'h00000000, 0, 0, 1);
    idle();
    drain();

    // Stall with tags 1..5
    stall_arm = 1;
    send(0, 0, 64'd1, 4'd1, 64'h3F800000, 0, 0, 0);
    send(0, 0, 64'd2, 4'd2, 64'h40000000, 0, 0, 0);
    send(0, 0, 64'd3, 4'd3, 64'h40400000, 0, 0, 0);
    send(0, 0, 64'd4, 4'd4, 64'h40800000, 0, 0, 0);
    send(0, 0, 64'd5, 4'd5, 64'h40A00000, 0, 0, 0);
    idle();
    drain();
    chk("stall observed", {63'd0, saw_stall}, 64'd1);

    // Reset with three transactions in flight
    send(0, 0, 64'd7, 4'd7, 64'd0, 0, 0, 0);
    send(0, 0, 64'd8, 4'd8, 64'd0, 0, 0, 0);
    send(0, 0, 64'd9, 4'd9, 64'd0, 0, 0, 0);
    chk("out_valid before reset", {63'd0, a_out_valid}, 64'd1);
    rst = 1;
    idle();
    #1 chk("out_valid async reset", {63'd0, a_out_valid}, 64'd0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1 chk("out_data in reset", {32'd0, a_out_data}, 64'd0);
    rst = 0;
    send(0, 0, 64'd6, 4'd9, 64'h40C00000, 0, 0, 1);
    idle();
    drain();

    // 64-bit instance
    send(1, 0, 64'h0000000000000001, 4'd1, 64'h3FF0000000000000, 0, 0, 1);
    send(1, 0, 64'h0020000000000001, 4'd2, 64'h4340000000000000, 1, 0, 1);
    send(1, 1, 64'hC3E0000000000000, 4'd3, 64'h8000000000000000, 0, 0, 1);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
